// File: rtl/ppc_pkg.sv
// Shared core definitions: register-file defaults, register index type, syscall register numbers.
// Pure declarations; no latency and no flow control.
package ppc_pkg;

    localparam int GPR_XLEN = 64;
    localparam int GPR_NREG = 32;

    typedef logic [$clog2(GPR_NREG)-1:0] reg_idx_t;

    // The sc convention takes its code in r0 and its argument in r3.
    localparam reg_idx_t GPR_SC_CODE = reg_idx_t'(0);
    localparam reg_idx_t GPR_SC_ARG  = reg_idx_t'(3);

endpackage

// File: rtl/gpr_bypass_mux.sv
// One read port's view of all write ports: bypass data and hit flag (highest-indexed match wins).
// Purely combinational, zero latency, no backpressure.
module gpr_bypass_mux
    import ppc_pkg::*;
#(
    parameter int XLEN = GPR_XLEN,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]        rd_addr,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [0:NWR*XLEN-1]  wr_data,
    output logic [0:XLEN-1]      byp_data,
    output logic                 wr_hit
);

    always_comb begin
        byp_data = '0;
        wr_hit   = 1'b0;
        // Ascending scan so a later (higher-indexed) match overrides earlier ones.
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr)) begin
                byp_data = wr_data[i*XLEN +: XLEN];
                wr_hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_file_bypass.sv
// GPR file with write-to-read bypass and pending-write scoreboard; read latency 0 (SYNC_READ=0) or 1.
// No backpressure: every input is consumed each cycle; rd_busy is always combinational.
module gpr_file_bypass
    import ppc_pkg::*;
#(
    parameter int XLEN      = GPR_XLEN,
    parameter int NREG      = GPR_NREG,
    parameter int NRD       = 3,
    parameter int NWR       = 2,
    parameter int SYNC_READ = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRD-1:0]              rd_en,
    input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
    output logic [0:NRD*XLEN-1]         rd_data,
    output logic [NRD-1:0]              rd_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*$clog2(NREG)-1:0] wr_addr,
    input  logic [0:NWR*XLEN-1]         wr_data,
    input  logic                        rsv_en,
    input  logic [$clog2(NREG)-1:0]     rsv_addr,
    input  logic                        flush,
    output logic [NREG-1:0]             busy
);

    localparam int AW = $clog2(NREG);

    logic [0:XLEN-1]     mem_q [NREG];
    logic [NREG-1:0]     busy_q, busy_d;
    logic [0:NRD*XLEN-1] rd_data_d;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            in_range;
        logic            hit;
        logic [0:XLEN-1] byp;
        logic [0:XLEN-1] arr;

        assign addr     = rd_addr[p*AW +: AW];
        assign in_range = int'(addr) < NREG;
        assign arr      = in_range ? mem_q[addr] : '0;

        gpr_bypass_mux #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_mux (
            .rd_addr  (addr),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .byp_data (byp),
            .wr_hit   (hit)
        );

        assign rd_data_d[p*XLEN +: XLEN] = !rd_en[p] ? '0 : (hit ? byp : arr);
        assign rd_busy[p] = rd_en[p] & in_range & busy_q[addr] & ~hit;
    end

    // Non-blocking updates in port order leave the highest-indexed writer in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (int'(wr_addr[i*AW +: AW]) < NREG)) begin
                    mem_q[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Flush first, then writeback releases, then the new reservation wins.
    always_comb begin
        busy_d = flush ? '0 : busy_q;
        for (int i = 0; i < NWR; i++) begin
            if (wr_en[i] && (int'(wr_addr[i*AW +: AW]) < NREG)) begin
                busy_d[wr_addr[i*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_en && (int'(rsv_addr) < NREG)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    if (SYNC_READ != 0) begin : g_sync
        logic [0:NRD*XLEN-1] rd_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end else begin : g_comb
        assign rd_data = rd_data_d;
    end

endmodule

// File: doc/gpr_file_bypass.md
# gpr_file_bypass

Parametrised general-purpose register file with write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (reads and reservations) and writeback (writes and releases) of the pipelined core, and replaces the fixed two-read/two-write `regs` instance plus the hand-built one-cycle-old forwarding registers. Decode uses `rd_busy` to stall on operands that still have an outstanding producer.

## Interface
- `XLEN`, default 64: register width; all data vectors are numbered `[0:XLEN-1]`, bit 0 is the MSB.
- `NREG`, default 32: number of registers. Address width `AW = $clog2(NREG)` is a localparam.
- `NRD`, default 3: number of read ports.
- `NWR`, default 2: number of write ports.
- `SYNC_READ`, default 0: read mode. 0 gives combinational read data; 1 gives registered read data with 1-cycle latency.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rd_en`, in, NRD: per-port read enable.
- `rd_addr`, in, NRD*AW: read addresses; port p is slice p.
- `rd_data`, out, NRD*XLEN: read data; port p is slice p.
- `rd_busy`, out, NRD: the addressed register has an outstanding reservation not satisfied this cycle.
- `wr_en`, in, NWR: per-port write enable.
- `wr_addr`, in, NWR*AW: write addresses.
- `wr_data`, in, NWR*XLEN: write data.
- `rsv_en`, in, 1: reserve `rsv_addr` as having a pending producer.
- `rsv_addr`, in, AW: register to reserve.
- `flush`, in, 1: clear all reservations (branch redirect).
- `busy`, out, NREG: scoreboard state, bit r corresponds to register r.

## Operation
- **Reset** (`rst_n` = 0, asynchronous):
  - all registers are 0;
  - `busy` is all 0;
  - with `SYNC_READ`=1, `rd_data` is 0.
  - Reset asserted mid-operation discards in-flight writes and reservations of that cycle.
- **Register 0** is an ordinary register. It is not hardwired to zero; the `sc` convention reads r0 and r3.
- **Write conflict.** When several write ports target the same address in one cycle, the highest-indexed port wins.
- **Read data** for port p:
  - `rd_en[p]`=0 returns 0.
  - Otherwise, if any enabled write port targets `rd_addr[p]` this cycle, it returns that write's data, using the highest-indexed matching port.
  - Otherwise it returns the array contents.
- **Scoreboard:**
  - `rsv_en` sets `busy[rsv_addr]`.
  - Any enabled write to register r clears `busy[r]`.
  - Reserve and write to the same r in one cycle leaves `busy[r]`=1 (the new producer wins).
  - `flush` clears every busy bit. If `flush` and `rsv_en` are both asserted, the flush is applied first, so only `busy[rsv_addr]`=1 afterwards.
  - Reserving an already-busy register keeps it busy. There is no count; one producer per register is guaranteed by decode.
- **`rd_busy[p]`** = `rd_en[p]` & `busy[rd_addr[p]]` & ~(any enabled write to `rd_addr[p]` this cycle). It is always combinational, regardless of `SYNC_READ`.

## Timing
- **Writes** commit at the rising edge on which `wr_en` is sampled.
- **`SYNC_READ`=0:** `rd_data` is valid in the same cycle as `rd_addr`, including same-cycle bypass. Latency is 0.
- **`SYNC_READ`=1:** `rd_data` is captured at the edge and is valid in the following cycle. The captured value includes bypass of writes that commit on that same edge. Writes in the following cycle are not reflected until the next read.
- **`busy`** updates at the edge and is visible the cycle after `rsv_en`. A same-cycle reserve-then-read does not report busy.
- There is no internal stall or backpressure: every input is consumed every cycle.

## Structure
- Shared package `ppc_pkg` holds:
  - `XLEN`, `NREG` defaults;
  - `reg_idx_t` typedef;
  - constants `GPR_SC_CODE` = 0 and `GPR_SC_ARG` = 3.
- One sub-module, `gpr_bypass_mux`, is instantiated NRD times. It takes one read address plus all write ports and produces bypassed data and the write-hit flag used for `rd_busy`.
- The register array and scoreboard stay in the top module.

## Test plan
- **Reset, then read:** assert `rst_n`=0 mid-run, then read r5 on all ports -> all `rd_data` = 0 and `busy` = 0.
- **Bypass:** in one cycle, write r7 = 0x1234 on port 0 and read r7 on port 2 -> `rd_data[2]` = 0x1234 the same cycle (`SYNC_READ`=0), or the next cycle (`SYNC_READ`=1).
- **Write conflict:** write r3 = 0xAA on port 0 and r3 = 0xBB on port 1 in the same cycle -> a later read of r3 = 0xBB.
- **Scoreboard lifecycle:**
  - reserve r4 -> next cycle a read of r4 gives `rd_busy`=1;
  - write r4 = 9 -> that cycle `rd_busy`=0 and `rd_data` = 9;
  - next cycle `busy[4]`=0.
- **Simultaneous reserve and write:** reserve r4 and write r4 in the same cycle -> `busy[4]`=1 afterwards.
- **Flush:** with r2 and r8 busy, assert `flush` together with reserve r9 -> `busy` = only bit 9 set.
